// File: rtl/sha.sv
// Shared SHA type definitions.
// mode_t selects the hash algorithm; it travels with each message from the
// padder to sha_engine.
package sha;

  typedef enum logic [2:0] {
    sha1       = 3'd0,
    sha224     = 3'd1,
    sha256     = 3'd2,
    sha384     = 3'd3,
    sha512     = 3'd4,
    sha512_224 = 3'd5,
    sha512_256 = 3'd6
  } mode_t;

endpackage

// File: rtl/sha_msg_padder.sv
// sha_msg_padder: byte-stream front end for sha_engine. Collects message
// bytes into blocks, appends the 0x80 marker, zero fill and big-endian bit
// length, and hands complete 512/1024-bit blocks to the engine with
// first/last flags.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        byte handshake from the source
//   in_data, in_last         message byte, final-byte marker
//   in_mode                  hash mode, sampled with the first byte
//   out_valid/out_ready      block handshake towards the engine
//   out_msg                  padded block (512-bit modes use [511:0])
//   out_mode                 mode of the message in flight
//   out_first, out_last      block is first / final of its message
module sha_msg_padder #(
  parameter int unsigned LEN_W = 61
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  input  logic          in_last,
  input  sha::mode_t    in_mode,
  output logic          in_ready,
  output logic          out_valid,
  output logic [1023:0] out_msg,
  output sha::mode_t    out_mode,
  output logic          out_first,
  output logic          out_last,
  input  logic          out_ready
);

  localparam int unsigned BLK_W = 1024;
  localparam int unsigned IDX_W = 7;

  typedef enum logic [1:0] {FILL, PAD, LENBLK, SEND} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [LEN_W-1:0] bytes;
  logic             first_pend;
  logic             need_len;
  logic             pad_pend;

  // 1024-bit block modes
  function automatic logic is_big(input sha::mode_t m);
    return (m == sha::sha384) || (m == sha::sha512) ||
           (m == sha::sha512_224) || (m == sha::sha512_256);
  endfunction

  logic             first_byte_c;
  sha::mode_t       cur_mode_c;
  logic             cur_big_c;
  logic             blk_big_c;
  logic [9:0]       bit_off_c;
  logic [9:0]       byte_hi_c;
  logic [IDX_W-1:0] last_idx_c;
  logic [LEN_W+2:0] bit_len_c;
  logic [BLK_W-1:0] len_field_c;
  logic [BLK_W-1:0] keep_c;
  logic [BLK_W-1:0] marker_c;
  logic             fits_c;
  logic [BLK_W-1:0] pad_blk_c;

  // Write position and padding images for the current block
  always_comb begin
    first_byte_c = (bytes == '0);
    // The first byte of a message must be placed using the incoming mode
    cur_mode_c   = first_byte_c ? in_mode : out_mode;
    cur_big_c    = is_big(cur_mode_c);
    blk_big_c    = is_big(out_mode);
    bit_off_c    = {idx, 3'b000};
    byte_hi_c    = (cur_big_c ? 10'd1023 : 10'd511) - bit_off_c;
    last_idx_c   = cur_big_c ? IDX_W'(127) : IDX_W'(63);
    bit_len_c    = {bytes, 3'b000};
    len_field_c  = blk_big_c ? BLK_W'(128'(bit_len_c)) : BLK_W'(64'(bit_len_c));
    // Keep message bytes below idx; everything from idx on is rewritten
    keep_c       = blk_big_c ? ~({BLK_W{1'b1}} >> bit_off_c)
                             : {512'b0, ~({512{1'b1}} >> bit_off_c)};
    marker_c     = BLK_W'(8'h80) << ((blk_big_c ? 10'd1016 : 10'd504) - bit_off_c);
    // Length fits behind the marker if idx+1 <= B-L
    fits_c       = blk_big_c ? (idx <= IDX_W'(111)) : (idx <= IDX_W'(55));
    pad_blk_c    = (out_msg & keep_c) | marker_c | (fits_c ? len_field_c : '0);
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_msg    <= '0;
      out_mode   <= sha::sha1;
      out_first  <= 1'b0;
      out_last   <= 1'b0;
      idx        <= '0;
      bytes      <= '0;
      first_pend <= 1'b0;
      need_len   <= 1'b0;
      pad_pend   <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (!in_ready) begin
            in_ready <= 1'b1;
          end else if (in_valid) begin
            if (first_byte_c) begin
              // Clearing the whole block keeps unused upper half zero
              out_msg    <= '0;
              out_mode   <= in_mode;
              first_pend <= 1'b1;
            end
            out_msg[byte_hi_c -: 8] <= in_data;
            bytes <= bytes + LEN_W'(1);
            if (idx == last_idx_c) begin
              // Block full; a final byte here still needs a padding block
              idx       <= '0;
              state     <= SEND;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_first <= first_pend;
              out_last  <= 1'b0;
              pad_pend  <= in_last;
            end else begin
              idx <= idx + IDX_W'(1);
              if (in_last) begin
                state    <= PAD;
                in_ready <= 1'b0;
              end
            end
          end
        end
        PAD: begin
          out_msg   <= pad_blk_c;
          out_last  <= fits_c;
          need_len  <= !fits_c;
          out_first <= first_pend;
          out_valid <= 1'b1;
          idx       <= '0;
          state     <= SEND;
        end
        LENBLK: begin
          out_msg   <= len_field_c;
          out_last  <= 1'b1;
          out_first <= first_pend;
          out_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            first_pend <= 1'b0;
            if (need_len) begin
              need_len <= 1'b0;
              state    <= LENBLK;
            end else if (pad_pend) begin
              pad_pend <= 1'b0;
              state    <= PAD;
            end else begin
              state    <= FILL;
              in_ready <= 1'b1;
              if (out_last) bytes <= '0;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_msg_padder.sv
// Directed testbench for sha_msg_padder with hand-computed padded blocks.
module tb_sha_msg_padder;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_last;
  sha::mode_t    in_mode;
  logic          in_ready;
  logic          out_valid;
  logic [1023:0] out_msg;
  sha::mode_t    out_mode;
  logic          out_first;
  logic          out_last;
  logic          out_ready;

  int errors = 0;
  int checks = 0;

  logic [1023:0] cap_msg;
  sha::mode_t    cap_mode;
  logic          cap_first;
  logic          cap_last;

  sha_msg_padder #(.LEN_W(61)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_mode   (in_mode),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_msg   (out_msg),
    .out_mode  (out_mode),
    .out_first (out_first),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Offer one byte and return #1 after the edge that accepted it
  task automatic put_byte(input logic [7:0] d, input logic last, input sha::mode_t m);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_mode  = m;
    while (in_ready !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 300) begin
      checks++; errors++;
      $display("FAIL put_byte_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait for a block, capture it, then complete the handshake
  task automatic get_block();
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 300) begin
      checks++; errors++;
      $display("FAIL get_block_timeout: out_valid=%b required 1", out_valid);
    end
    cap_msg   = out_msg;
    cap_mode  = out_mode;
    cap_first = out_first;
    cap_last  = out_last;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_msg !== 1024'b0) begin errors++; $display("FAIL reset_out_msg: got nonzero want 0"); end
    checks++; if (out_first !== 1'b0 || out_last !== 1'b0) begin errors++; $display("FAIL reset_flags: got first=%b last=%b want 0 0", out_first, out_last); end
    checks++; if (out_mode !== sha::sha1) begin errors++; $display("FAIL reset_mode: got %0d want %0d", out_mode, sha::sha1); end
    rst = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_release_in_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b want 1", in_ready); end
  endtask

  task automatic test_abc();
    logic [1023:0] exp;
    exp = '0;
    exp[511:480] = 32'h61626380;
    exp[63:0]    = 64'h18;
    put_byte(8'h61, 1'b0, sha::sha256);
    put_byte(8'h62, 1'b0, sha::sha256);
    put_byte(8'h63, 1'b1, sha::sha256);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abc_valid_pad_cycle: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL abc_ready_pad_cycle: got %b want 0", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL abc_latency: got %b want 1", out_valid); end
    get_block();
    checks++; if (cap_msg[511:0] !== exp[511:0]) begin errors++; $display("FAIL abc_lo: got %h want %h", cap_msg[511:0], exp[511:0]); end
    checks++; if (cap_msg[1023:512] !== exp[1023:512]) begin errors++; $display("FAIL abc_hi: got %h want %h", cap_msg[1023:512], exp[1023:512]); end
    checks++; if (cap_first !== 1'b1 || cap_last !== 1'b1) begin errors++; $display("FAIL abc_flags: got first=%b last=%b want 1 1", cap_first, cap_last); end
    checks++; if (cap_mode !== sha::sha256) begin errors++; $display("FAIL abc_mode: got %0d want %0d", cap_mode, sha::sha256); end
  endtask

  task automatic test_hello();
    logic [7:0]    msg [11];
    logic [1023:0] exp;
    msg = '{8'h68, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h20, 8'h77, 8'h6f, 8'h72, 8'h6c, 8'h64};
    exp = '0;
    exp[511:416] = 96'h68656c6c6f20776f726c6480;
    exp[63:0]    = 64'h58;
    for (int i = 0; i < 11; i++) put_byte(msg[i], (i == 10), sha::sha256);
    get_block();
    checks++; if (cap_msg[511:0] !== exp[511:0]) begin errors++; $display("FAIL hello_lo: got %h want %h", cap_msg[511:0], exp[511:0]); end
    checks++; if (cap_msg[1023:512] !== exp[1023:512]) begin errors++; $display("FAIL hello_hi: got %h want %h", cap_msg[1023:512], exp[1023:512]); end
    checks++; if (cap_first !== 1'b1 || cap_last !== 1'b1) begin errors++; $display("FAIL hello_flags: got first=%b last=%b want 1 1", cap_first, cap_last); end
  endtask

  task automatic test_len_overflow();
    logic [1023:0] exp;
    exp = '0;
    exp[511:64] = {56{8'h61}};
    exp[63:56]  = 8'h80;
    for (int i = 0; i < 56; i++) put_byte(8'h61, (i == 55), sha::sha256);
    get_block();
    checks++; if (cap_msg !== exp) begin errors++; $display("FAIL b56_blk1: got %h want %h", cap_msg[511:0], exp[511:0]); end
    checks++; if (cap_first !== 1'b1 || cap_last !== 1'b0) begin errors++; $display("FAIL b56_blk1_flags: got first=%b last=%b want 1 0", cap_first, cap_last); end
    exp = '0;
    exp[63:0] = 64'h1c0;
    get_block();
    checks++; if (cap_msg !== exp) begin errors++; $display("FAIL b56_blk2: got %h want %h", cap_msg[511:0], exp[511:0]); end
    checks++; if (cap_first !== 1'b0 || cap_last !== 1'b1) begin errors++; $display("FAIL b56_blk2_flags: got first=%b last=%b want 0 1", cap_first, cap_last); end
  endtask

  task automatic test_back_to_back();
    logic [1023:0] exp;
    for (int i = 0; i < 64; i++) put_byte(8'h00, (i == 63), sha::sha512);
    exp = '0;
    exp[511:504] = 8'h80;
    exp[127:0]   = 128'h200;
    get_block();
    checks++; if (cap_msg[511:0] !== exp[511:0]) begin errors++; $display("FAIL s512_lo: got %h want %h", cap_msg[511:0], exp[511:0]); end
    checks++; if (cap_msg[1023:512] !== exp[1023:512]) begin errors++; $display("FAIL s512_hi: got %h want %h", cap_msg[1023:512], exp[1023:512]); end
    checks++; if (cap_mode !== sha::sha512) begin errors++; $display("FAIL s512_mode: got %0d want %0d", cap_mode, sha::sha512); end
    checks++; if (cap_first !== 1'b1 || cap_last !== 1'b1) begin errors++; $display("FAIL s512_flags: got first=%b last=%b want 1 1", cap_first, cap_last); end
    for (int i = 0; i < 64; i++) put_byte(8'h5a, (i == 63), sha::sha256);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_blk_latency: got %b want 1", out_valid); end
    exp = '0;
    exp[511:0] = {64{8'h5a}};
    get_block();
    checks++; if (cap_msg[511:0] !== exp[511:0]) begin errors++; $display("FAIL s256b1_lo: got %h want %h", cap_msg[511:0], exp[511:0]); end
    checks++; if (cap_msg[1023:512] !== exp[1023:512]) begin errors++; $display("FAIL s256b1_hi: got %h want %h", cap_msg[1023:512], exp[1023:512]); end
    checks++; if (cap_first !== 1'b1 || cap_last !== 1'b0) begin errors++; $display("FAIL s256b1_flags: got first=%b last=%b want 1 0", cap_first, cap_last); end
    checks++; if (cap_mode !== sha::sha256) begin errors++; $display("FAIL s256_mode: got %0d want %0d", cap_mode, sha::sha256); end
    exp = '0;
    exp[511:504] = 8'h80;
    exp[63:0]    = 64'h200;
    get_block();
    checks++; if (cap_msg !== exp) begin errors++; $display("FAIL s256b2: got %h want %h", cap_msg[511:0], exp[511:0]); end
    checks++; if (cap_first !== 1'b0 || cap_last !== 1'b1) begin errors++; $display("FAIL s256b2_flags: got first=%b last=%b want 0 1", cap_first, cap_last); end
  endtask

  task automatic test_backpressure();
    logic [1023:0] exp;
    int n;
    exp = '0;
    exp[511:496] = 16'h4180;
    exp[63:0]    = 64'h8;
    put_byte(8'h41, 1'b1, sha::sha224);
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (n == 50) begin errors++; $display("FAIL bp_valid_timeout: out_valid=%b want 1", out_valid); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: cycle %0d got %b want 1", c, out_valid); end
      checks++; if (out_msg !== exp) begin errors++; $display("FAIL bp_hold_msg: cycle %0d got %h want %h", c, out_msg[511:0], exp[511:0]); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: cycle %0d got %b want 0", c, in_ready); end
      checks++; if (out_first !== 1'b1 || out_last !== 1'b1 || out_mode !== sha::sha224) begin errors++; $display("FAIL bp_hold_tags: got first=%b last=%b mode=%0d want 1 1 %0d", out_first, out_last, out_mode, sha::sha224); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drop_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_back_to_fill: got %b want 1", in_ready); end
  endtask

  task automatic test_rst_mid();
    logic [1023:0] exp;
    for (int i = 0; i < 30; i++) put_byte(8'h33, 1'b0, sha::sha256);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_block: got %b want 0", out_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_ctrl: got ready=%b valid=%b want 0 0", in_ready, out_valid); end
    checks++; if (out_msg !== 1024'b0) begin errors++; $display("FAIL mid_reset_msg: got %h want 0", out_msg[511:0]); end
    put_byte(8'h61, 1'b0, sha::sha1);
    put_byte(8'h62, 1'b0, sha::sha1);
    put_byte(8'h63, 1'b1, sha::sha1);
    exp = '0;
    exp[511:480] = 32'h61626380;
    exp[63:0]    = 64'h18;
    get_block();
    checks++; if (cap_msg !== exp) begin errors++; $display("FAIL mid_sha1_msg: got %h want %h", cap_msg[511:0], exp[511:0]); end
    checks++; if (cap_mode !== sha::sha1) begin errors++; $display("FAIL mid_sha1_mode: got %0d want %0d", cap_mode, sha::sha1); end
    checks++; if (cap_first !== 1'b1 || cap_last !== 1'b1) begin errors++; $display("FAIL mid_sha1_flags: got first=%b last=%b want 1 1", cap_first, cap_last); end
    repeat (10) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_extra_block: got %b want 0", out_valid); end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    in_mode   = sha::sha256;
    out_ready = 1'b0;
    test_reset();
    test_abc();
    test_hello();
    test_len_overflow();
    test_back_to_back();
    test_backpressure();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
